// File: rtl/matmul_seq_controller.sv
// Sequencer for the matrix-multiply datapath: loads A/B, runs MAC over
// every (i,j,k), writes C, then streams each C word out in BEATS slices.
module matmul_seq_controller #(
  parameter int M      = 3,
  parameter int K      = 3,
  parameter int N      = 3,
  parameter int ADDR_W = 8,
  parameter int BEATS  = 3,
  parameter int SH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reload,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              mem_a_en,
  output logic              mem_a_we,
  output logic              mem_b_en,
  output logic              mem_b_we,
  output logic              mem_c_en,
  output logic              mem_c_we,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic              mac_ld,
  output logic              mac_clr,
  output logic [SH_W-1:0]   shift_cnt,
  output logic              out_valid,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_RD, S_MAC,
    S_WR, S_OUT_RD, S_OUT_SH, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] KA     = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] NA     = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(M*K-1);
  localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'(K*N-1);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(M*N-1);
  localparam logic [ADDR_W-1:0] M_LAST = ADDR_W'(M-1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(K-1);
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(N-1);
  localparam logic [SH_W-1:0]   S_LAST = SH_W'(BEATS-1);
  localparam logic [ADDR_W-1:0] A1     = ADDR_W'(1);

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_i, w_i;
  logic [ADDR_W-1:0] r_j, w_j;
  logic [ADDR_W-1:0] r_k, w_k;
  logic [ADDR_W-1:0] r_outi, w_outi;
  logic [SH_W-1:0]   r_sh, w_sh;
  logic [ADDR_W-1:0] r_addr_a, w_addr_a;
  logic [ADDR_W-1:0] r_addr_b, w_addr_b;
  logic [ADDR_W-1:0] r_addr_c, w_addr_c;
  logic              r_a_en, w_a_en, r_a_we, w_a_we;
  logic              r_b_en, w_b_en, r_b_we, w_b_we;
  logic              r_c_en, w_c_en, r_c_we, w_c_we;
  logic              r_ld, w_ld, r_clr, w_clr;
  logic              r_ov, w_ov, r_done, w_done;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_i      = r_i;
    w_j      = r_j;
    w_k      = r_k;
    w_outi   = r_outi;
    w_sh     = r_sh;
    w_addr_a = r_addr_a;
    w_addr_b = r_addr_b;
    w_addr_c = r_addr_c;
    w_a_en   = 1'b0;
    w_a_we   = 1'b0;
    w_b_en   = 1'b0;
    w_b_we   = 1'b0;
    w_c_en   = 1'b0;
    w_c_we   = 1'b0;
    w_ld     = 1'b0;
    w_clr    = 1'b0;
    w_ov     = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state = reload ? S_LOAD_A : S_RD;
      end
      S_LOAD_A: begin
        if (in_valid) begin
          w_a_en   = 1'b1;
          w_a_we   = 1'b1;
          w_addr_a = r_cnt;
          if (r_cnt == A_LAST) begin
            w_cnt   = '0;
            w_state = S_LOAD_B;
          end else begin
            w_cnt = r_cnt + A1;
          end
        end
      end
      S_LOAD_B: begin
        if (in_valid) begin
          w_b_en   = 1'b1;
          w_b_we   = 1'b1;
          w_addr_b = r_cnt;
          if (r_cnt == B_LAST) begin
            w_cnt   = '0;
            w_state = S_RD;
          end else begin
            w_cnt = r_cnt + A1;
          end
        end
      end
      S_RD: begin
        w_a_en   = 1'b1;
        w_b_en   = 1'b1;
        w_addr_a = r_i * KA + r_k;
        w_addr_b = r_k * NA + r_j;
        w_state  = S_MAC;
      end
      S_MAC: begin
        w_ld = 1'b1;
        if (r_k == K_LAST) begin
          w_k     = '0;
          w_state = S_WR;
        end else begin
          w_k     = r_k + A1;
          w_state = S_RD;
        end
      end
      S_WR: begin
        w_c_en   = 1'b1;
        w_c_we   = 1'b1;
        w_clr    = 1'b1;
        w_addr_c = r_i * NA + r_j;
        if (r_j == N_LAST) begin
          w_j = '0;
          w_i = r_i + A1;
        end else begin
          w_j = r_j + A1;
        end
        if (r_i == M_LAST && r_j == N_LAST) begin
          w_i     = '0;
          w_state = S_OUT_RD;
        end else begin
          w_state = S_RD;
        end
      end
      S_OUT_RD: begin
        w_c_en   = 1'b1;
        w_addr_c = r_outi;
        w_sh     = '0;
        w_state  = S_OUT_SH;
      end
      S_OUT_SH: begin
        // first cycle here waits out the C read latency
        if (!r_ov) begin
          w_ov = 1'b1;
        end else if (out_ready) begin
          if (r_sh == S_LAST) begin
            if (r_outi == C_LAST) begin
              w_outi  = '0;
              w_state = S_DONE;
            end else begin
              w_outi  = r_outi + A1;
              w_state = S_OUT_RD;
            end
          end else begin
            w_sh = r_sh + SH_W'(1);
            w_ov = 1'b1;
          end
        end else begin
          w_ov = 1'b1;
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_outi   <= '0;
      r_sh     <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_a_en   <= 1'b0;
      r_a_we   <= 1'b0;
      r_b_en   <= 1'b0;
      r_b_we   <= 1'b0;
      r_c_en   <= 1'b0;
      r_c_we   <= 1'b0;
      r_ld     <= 1'b0;
      r_clr    <= 1'b0;
      r_ov     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_i      <= w_i;
      r_j      <= w_j;
      r_k      <= w_k;
      r_outi   <= w_outi;
      r_sh     <= w_sh;
      r_addr_a <= w_addr_a;
      r_addr_b <= w_addr_b;
      r_addr_c <= w_addr_c;
      r_a_en   <= w_a_en;
      r_a_we   <= w_a_we;
      r_b_en   <= w_b_en;
      r_b_we   <= w_b_we;
      r_c_en   <= w_c_en;
      r_c_we   <= w_c_we;
      r_ld     <= w_ld;
      r_clr    <= w_clr;
      r_ov     <= w_ov;
      r_done   <= w_done;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_a_en  = r_a_en;
  assign mem_a_we  = r_a_we;
  assign mem_b_en  = r_b_en;
  assign mem_b_we  = r_b_we;
  assign mem_c_en  = r_c_en;
  assign mem_c_we  = r_c_we;
  assign addr_a    = r_addr_a;
  assign addr_b    = r_addr_b;
  assign addr_c    = r_addr_c;
  assign mac_ld    = r_ld;
  assign mac_clr   = r_clr;
  assign shift_cnt = r_sh;
  assign out_valid = r_ov;
  assign done      = r_done;

endmodule

// File: tb/tb_matmul_seq_controller.sv
// Scoreboard bench: models memories A/B/C and the MAC around the sequencer,
// with A=[[1,2,3],[4,5,6]], B=[[1,2],[3,4],[5,6]] so C=[[22,28],[49,64]].
module tb_matmul_seq_controller;
  localparam int TM = 2;
  localparam int TK = 3;
  localparam int TN = 2;
  localparam int AW = 8;
  localparam int BT = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, reload, in_valid, out_ready;
  logic          busy;
  logic          mem_a_en, mem_a_we, mem_b_en, mem_b_we;
  logic          mem_c_en, mem_c_we;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic          mac_ld, mac_clr;
  logic [SW-1:0] shift_cnt;
  logic          out_valid, done;

  matmul_seq_controller #(
    .M(TM), .K(TK), .N(TN), .ADDR_W(AW), .BEATS(BT), .SH_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .reload(reload),
    .in_valid(in_valid), .out_ready(out_ready), .busy(busy),
    .mem_a_en(mem_a_en), .mem_a_we(mem_a_we),
    .mem_b_en(mem_b_en), .mem_b_we(mem_b_we),
    .mem_c_en(mem_c_en), .mem_c_we(mem_c_we),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .mac_ld(mac_ld), .mac_clr(mac_clr), .shift_cnt(shift_cnt),
    .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_wc = 0;
  int n_done = 0;
  int exp_done = 0;
  int cref[4] = '{22, 28, 49, 64};

  int wq[$];
  int exp_wa[$], exp_wb[$], exp_wc[$];
  int exp_ow[$], exp_os[$];

  int memA[256], memB[256], memC[256];
  int rdA = 0, rdB = 0, rdC = 0, acc = 0;

  function automatic void check(input string nm, input int act,
                                input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // memory and accumulator model driven by the DUT strobes
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 0;
    end else begin
      if (mem_a_en && mem_a_we && wq.size() > 0)
        memA[addr_a] <= wq.pop_front();
      if (mem_b_en && mem_b_we && wq.size() > 0)
        memB[addr_b] <= wq.pop_front();
      if (mem_a_en && !mem_a_we) rdA <= memA[addr_a];
      if (mem_b_en && !mem_b_we) rdB <= memB[addr_b];
      if (mem_c_en && mem_c_we) memC[addr_c] <= acc;
      if (mem_c_en && !mem_c_we) rdC <= memC[addr_c];
      if (mac_clr) acc <= 0;
      else if (mac_ld) acc <= acc + rdA * rdB;
    end
  end

  // monitor
  always @(negedge clk) begin
    int e, s;
    if (rst) begin
      cyc++;
      if (mem_a_en && mem_a_we) begin
        e = exp_wa.size() > 0 ? exp_wa.pop_front() : -1;
        check("wr_a_addr", int'(addr_a), e);
      end
      if (mem_b_en && mem_b_we) begin
        e = exp_wb.size() > 0 ? exp_wb.pop_front() : -1;
        check("wr_b_addr", int'(addr_b), e);
      end
      if (mem_c_en && mem_c_we) begin
        e = exp_wc.size() > 0 ? exp_wc.pop_front() : -1;
        check("wr_c_addr", int'(addr_c), e);
        if (e > 0) check("wr_c_gap", cyc - last_wc, 2 * TK + 1);
        last_wc = cyc;
      end
      if (out_valid && out_ready) begin
        e = exp_ow.size() > 0 ? exp_ow.pop_front() : -1;
        s = exp_os.size() > 0 ? exp_os.pop_front() : -1;
        check("out_word", rdC, e);
        check("out_slice", int'(shift_cnt), s);
      end
      if (done) n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input bit rl, input bit tog,
                         input bit stall, input bit poke);
    bit stalled = 1'b0;
    bit poked = 1'b0;
    if (rl) begin
      for (int b = 0; b < TM * TK; b++) exp_wa.push_back(b);
      for (int b = 0; b < TK * TN; b++) exp_wb.push_back(b);
    end
    for (int e = 0; e < TM * TN; e++) begin
      exp_wc.push_back(e);
      for (int s = 0; s < BT; s++) begin
        exp_ow.push_back(cref[e]);
        exp_os.push_back(s);
      end
    end
    exp_done++;
    start = 1'b1;
    reload = rl;
    step();
    start = 1'b0;
    reload = 1'b0;
    check("busy_on", int'(busy), 1);
    if (rl) begin
      for (int b = 0; b < TM * TK; b++) begin
        in_valid = 1'b1;
        wq.push_back(b + 1);
        step();
      end
      for (int b = 0; b < TK * TN; b++) begin
        in_valid = 1'b1;
        wq.push_back(b + 1);
        step();
        if (tog) begin
          in_valid = 1'b0;
          step();
        end
      end
      in_valid = 1'b0;
    end else begin
      step();
      check("rd_first",
            int'({mem_a_en, mem_a_we, mem_b_en, mem_b_we}), 4'b1010);
    end
    if (poke) begin
      for (int t = 0; t < 50 && !(mem_a_en && !mem_a_we); t++) step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int t = 0; t < 3000 && n_done < exp_done; t++) begin
      if (stall && !stalled && out_valid && shift_cnt == 2'd1) begin
        out_ready = 1'b0;
        repeat (5) begin
          step();
          check("hold_valid", int'(out_valid), 1);
          check("hold_slice", int'(shift_cnt), 1);
        end
        out_ready = 1'b1;
        stalled = 1'b1;
      end
      if (poke && !poked && out_valid) begin
        start = 1'b1;
        step();
        start = 1'b0;
        poked = 1'b1;
      end
      step();
    end
    check("done_cnt", n_done, exp_done);
    repeat (3) step();
    check("drain", exp_wa.size() + exp_wb.size() + exp_wc.size()
                   + exp_ow.size(), 0);
    check("idle_after", int'(busy), 0);
    check("done_once", n_done, exp_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    reload = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    check("reset_strobes",
          int'({busy, mem_a_en, mem_a_we, mem_b_en, mem_b_we, mem_c_en,
                mem_c_we, mac_ld, mac_clr, out_valid, done}), 0);
    check("reset_addr", int'(addr_a | addr_b | addr_c), 0);
    check("reset_shift", int'(shift_cnt), 0);
    step();
    step();
    rst = 1'b1;
    step();

    // abort part-way through loading A
    start = 1'b1;
    reload = 1'b1;
    step();
    start = 1'b0;
    reload = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b < 3) exp_wa.push_back(b);
      wq.push_back(100 + b);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst", int'({busy, mem_a_en, mem_a_we}), 3'b111);
    check("pre_rst_addr", int'(addr_a), 3);
    rst = 1'b0;
    #1;
    check("rst_abort",
          int'({busy, mem_a_en, mem_a_we, mem_b_en, mem_b_we, mem_c_en,
                mem_c_we, mac_ld, mac_clr, out_valid, done}), 0);
    check("rst_abort_addr", int'(addr_a), 0);
    check("rst_wa_seen", exp_wa.size(), 0);
    wq.delete();
    step();
    rst = 1'b1;
    step();

    run_job(1'b1, 1'b0, 1'b0, 1'b0);
    run_job(1'b0, 1'b0, 1'b1, 1'b0);
    run_job(1'b1, 1'b1, 1'b0, 1'b1);

    check("c_mem_00", memC[0], 22);
    check("c_mem_11", memC[3], 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq_controller.md
Name: matmul_seq_controller

Overview:
- Parametrised sequencer for the matrix-multiply datapath. It loads matrix A (M×K) and matrix B (K×N) into memories A and B, then drives the MAC unit over every (i,j,k) index.
- It writes C (M×N) into memory C, then streams each C word out in BEATS shift slices under a valid/ready handshake.
- It generalises the fixed square 8×8 sequencer:
  - independent M/K/N dimensions;
  - optional reuse of already-loaded operands;
  - back-pressured load and output.

Parameters:
M  3  rows of A and C
K  3  inner dimension (cols of A, rows of B)
N  3  cols of B and C
ADDR_W  8  memory address width; must satisfy 2^ADDR_W ≥ max(M*K, K*N, M*N)
BEATS  3  output shift slices per C word (≥1)
SH_W  2  shift_cnt width; 2^SH_W ≥ BEATS

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  begin a job; sampled only in IDLE
reload  input  1  sampled with start: 1 = load A and B first, 0 = reuse memory contents
in_valid  input  1  load data beat present on the memory write bus this cycle
out_ready  input  1  downstream accepts the current output slice
busy  output  1  job in progress
mem_a_en, mem_a_we  output  1 each  memory A enable and write enable
mem_b_en, mem_b_we  output  1 each  memory B enable and write enable
mem_c_en, mem_c_we  output  1 each  memory C enable and write enable
addr_a, addr_b, addr_c  output  ADDR_W each  memory addresses
mac_ld  output  1  accumulate the current A×B product
mac_clr  output  1  clear the accumulator
shift_cnt  output  SH_W  output slice select
out_valid  output  1  output slice valid
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; addresses 0.
  - Counters cnt, i, j, k, outi all 0.
  - Reset asserted mid-job aborts immediately with no further strobes.
- Output style: strobes (en/we/mac_ld/mac_clr/out_valid/done) are registered and default to 0 every cycle unless the state below asserts them.
- States: IDLE, LOAD_A, LOAD_B, RD, MAC, WR, OUT_RD, OUT_SH, DONE.
- busy: 1 in every state except IDLE.
- IDLE:
  - start=1 and reload=1 → LOAD_A.
  - start=1 and reload=0 → RD.
  - start outside IDLE is ignored.
- LOAD_A: on each in_valid=1 cycle: mem_a_en=mem_a_we=1, addr_a=cnt, cnt++.
  - in_valid=0 → no strobe, cnt holds.
  - After beat M*K−1: cnt=0 → LOAD_B.
- LOAD_B: same as LOAD_A on memory B for K*N beats → RD.
- RD:
  - mem_a_en=mem_b_en=1 with write enables 0.
  - addr_a=i*K+k; addr_b=k*N+j → MAC.
- MAC:
  - mac_ld=1 (memory read latency is one cycle, so data is valid here).
  - If k==K−1: k=0 → WR; else k++ → RD.
- WR:
  - mem_c_en=mem_c_we=1, addr_c=i*N+j, mac_clr=1 (accumulator captured into C before the clear takes effect).
  - If j==N−1: j=0, i++; else j++.
  - If the element just written was (M−1,N−1): i=0 → OUT_RD; else → RD.
- Compute latency: 2K+1 cycles per C element; M*N*(2K+1) cycles in total.
- OUT_RD: mem_c_en=1, addr_c=outi, shift_cnt=0 → OUT_SH.
- OUT_SH:
  - out_valid=1, held along with shift_cnt until out_ready=1.
  - On accept with shift_cnt<BEATS−1: shift_cnt++.
  - On accept with shift_cnt==BEATS−1:
    - outi==M*N−1 → outi=0, → DONE;
    - otherwise outi++ → OUT_RD.
  - out_ready=1 together with out_valid=1 is the transfer; out_ready while not valid is ignored.
- DONE: done=1 for exactly one cycle → IDLE.
- Address arithmetic:
  - Computed at ADDR_W width and truncated.
  - Row bases may be maintained as incremented registers (+K, +N) instead of multipliers; the resulting address values must match the formulas above.
- Degenerate dimension (K=1): RD/MAC execute once per element.

Test Plan:
- Reset mid-LOAD_A (M=K=N=3), drive rst=0 at beat 4 → all strobes and busy drop the same cycle; after release, start with reload=1 loads from addr_a=0.
- M=2, K=3, N=2, reload=1, in_valid always 1 → A beats on addr 0..5 and B beats on addr 0..5. WR addresses are 0,1,2,3, each occurring 7 cycles apart. C matches the reference product for A=1..6, B=1..6 ([[22,28],[49,64]]).
- in_valid toggling 1,0,1,0 during LOAD_B → write count still K*N; addr_b increments only on valid beats.
- reload=0 job after a completed job → no LOAD strobes; first RD occurs the cycle after start; results are identical to the prior job.
- Output with BEATS=3, out_ready low for 5 cycles on slice 1 → out_valid and shift_cnt=1 held stable; total accepted slices = 3*M*N; done pulses once.
- start asserted during RD and OUT_SH → ignored; job completes normally.
